// File: rtl/imm_pack.sv
// Immediate packer: range/alignment-checks an immediate and merges it into an RV32 instruction word
// through a 2-stage valid/ready pipeline. Optional saturating error counter enabled by IMM_PACK_ERRCNT_EN.
module imm_pack #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_imm,
    input  logic [2:0]       in_type,
    input  logic [24:0]      in_fields,
    input  logic [6:0]       in_opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [1:0]       out_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned IMM_W  = 32;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned FLD_W  = 25;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned ERR_W  = 2;

    localparam logic [TYPE_W-1:0] FMT_I = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] FMT_B = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] FMT_S = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] FMT_U = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] FMT_J = TYPE_W'(4);

    localparam logic [ERR_W-1:0] ERR_OK    = ERR_W'(0);
    localparam logic [ERR_W-1:0] ERR_RANGE = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_ALIGN = ERR_W'(2);
    localparam logic [ERR_W-1:0] ERR_TYPE  = ERR_W'(3);

    logic               s1_valid_q, s1_valid_d;
    logic [IMM_W-1:0]   s1_imm_q, s1_imm_d;
    logic [TYPE_W-1:0]  s1_type_q, s1_type_d;
    logic [FLD_W-1:0]   s1_fields_q, s1_fields_d;
    logic [OPC_W-1:0]   s1_opcode_q, s1_opcode_d;
    logic [ERR_W-1:0]   s1_err_q, s1_err_d;
    logic               out_valid_q, out_valid_d;
    logic [IMM_W-1:0]   out_instr_q, out_instr_d;
    logic [ERR_W-1:0]   out_err_q, out_err_d;

    logic               s2_ready_c;
    logic               s1_load_c;
    logic [ERR_W-1:0]   err_c;
    logic [IMM_W-1:0]   pack_c;

    assign s2_ready_c = !out_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_ready_c;
    assign s1_load_c  = in_valid && in_ready;

    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign out_err    = out_err_q;

    // Error classification on the incoming word; priority type > align > range
    always_comb begin
        logic type_ok;
        logic align_ok;
        logic range_ok;
        type_ok  = 1'b1;
        align_ok = 1'b1;
        range_ok = 1'b1;
        err_c    = ERR_OK;
        case (in_type)
            FMT_I, FMT_S: range_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
            FMT_B: begin
                range_ok = (&in_imm[31:12]) || !(|in_imm[31:12]);
                align_ok = !in_imm[0];
            end
            FMT_U: align_ok = (in_imm[11:0] == 12'h000);
            FMT_J: begin
                range_ok = (&in_imm[31:20]) || !(|in_imm[31:20]);
                align_ok = !in_imm[0];
            end
            default: type_ok = 1'b0;
        endcase
        if (!type_ok) begin
            err_c = ERR_TYPE;
        end else if (!align_ok) begin
            err_c = ERR_ALIGN;
        end else if (!range_ok) begin
            err_c = ERR_RANGE;
        end
    end

    // Scatter the stage-1 immediate into its format's instruction bit positions
    always_comb begin
        pack_c = {s1_fields_q, s1_opcode_q};
        case (s1_type_q)
            FMT_I: pack_c[31:20] = s1_imm_q[11:0];
            FMT_S: begin
                pack_c[31:25] = s1_imm_q[11:5];
                pack_c[11:7]  = s1_imm_q[4:0];
            end
            FMT_B: begin
                pack_c[31]    = s1_imm_q[12];
                pack_c[30:25] = s1_imm_q[10:5];
                pack_c[11:8]  = s1_imm_q[4:1];
                pack_c[7]     = s1_imm_q[11];
            end
            FMT_U: pack_c[31:12] = s1_imm_q[31:12];
            FMT_J: begin
                pack_c[31]    = s1_imm_q[20];
                pack_c[30:21] = s1_imm_q[10:1];
                pack_c[20]    = s1_imm_q[11];
                pack_c[19:12] = s1_imm_q[19:12];
            end
            default: pack_c[31:7] = '1;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_imm_d    = s1_imm_q;
        s1_type_d   = s1_type_q;
        s1_fields_d = s1_fields_q;
        s1_opcode_d = s1_opcode_q;
        s1_err_d    = s1_err_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_err_d   = out_err_q;
        if (s2_ready_c) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_instr_d = pack_c;
                out_err_d   = s1_err_q;
            end
        end
        if (s1_load_c) begin
            s1_valid_d  = 1'b1;
            s1_imm_d    = in_imm;
            s1_type_d   = in_type;
            s1_fields_d = in_fields;
            s1_opcode_d = in_opcode;
            s1_err_d    = err_c;
        end else if (s2_ready_c) begin
            s1_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_imm_q    <= '0;
            s1_type_q   <= '0;
            s1_fields_q <= '0;
            s1_opcode_q <= '0;
            s1_err_q    <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_err_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_imm_q    <= s1_imm_d;
            s1_type_q   <= s1_type_d;
            s1_fields_q <= s1_fields_d;
            s1_opcode_q <= s1_opcode_d;
            s1_err_q    <= s1_err_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_err_q   <= out_err_d;
        end
    end

`ifdef IMM_PACK_ERRCNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over a coincident increment; increment saturates at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid_q && out_ready && (out_err_q != ERR_OK) && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_count = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_imm_pack.sv
// Self-checking bench for imm_pack: directed steps plus randomized traffic against a reference model.
module tb_imm_pack;

`ifdef IMM_PACK_ERRCNT_EN
    localparam int unsigned CW = 2;
`else
    localparam int unsigned CW = 16;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_imm;
    logic [2:0]    in_type;
    logic [24:0]   in_fields;
    logic [6:0]    in_opcode;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [1:0]    out_err;
    logic          cnt_clr;
    logic [CW-1:0] err_count;

    imm_pack #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_type   (in_type),
        .in_fields (in_fields),
        .in_opcode (in_opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .cnt_clr   (cnt_clr),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [1:0]  err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks;
    int          failures;
    int          cnt_model;
    logic        stall_prev;
    logic [31:0] prev_instr;
    logic [1:0]  prev_err;
    logic        clr_req;

    function automatic exp_t model(input logic [31:0] imm, input logic [2:0] t,
                                   input logic [24:0] f, input logic [6:0] op);
        exp_t        r;
        int          s;
        logic [31:0] base;
        logic        rng_bad;
        logic        aln_bad;
        s       = int'($signed(imm));
        base    = {f, op};
        rng_bad = 1'b0;
        aln_bad = 1'b0;
        r.instr = base;
        case (t)
            3'd0: begin
                rng_bad = (s < -2048) || (s > 2047);
                r.instr = (base & 32'h000FFFFF) | ((imm & 32'hFFF) << 20);
            end
            3'd2: begin
                rng_bad = (s < -2048) || (s > 2047);
                r.instr = (base & ~32'hFE000F80) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            end
            3'd1: begin
                rng_bad = (s < -4096) || (s > 4095);
                aln_bad = (imm % 2) != 0;
                r.instr = (base & ~32'hFE000F80) | (((imm >> 12) & 32'd1) << 31)
                        | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                        | (((imm >> 11) & 32'd1) << 7);
            end
            3'd3: begin
                aln_bad = (imm % 4096) != 0;
                r.instr = (base & 32'hFFF) | (imm & 32'hFFFFF000);
            end
            3'd4: begin
                rng_bad = (s < -1048576) || (s > 1048575);
                aln_bad = (imm % 2) != 0;
                r.instr = (base & 32'hFFF) | (((imm >> 20) & 32'd1) << 31)
                        | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'd1) << 20)
                        | (((imm >> 12) & 32'hFF) << 12);
            end
            default: r.instr = 32'hFFFFFF80 | {25'd0, op};
        endcase
        if (t > 3'd4)      r.err = 2'b11;
        else if (aln_bad)  r.err = 2'b10;
        else if (rng_bad)  r.err = 2'b01;
        else               r.err = 2'b00;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive at the falling edge, check registered outputs, track transfers
    task automatic step(input logic v, input logic [31:0] imm, input logic [2:0] t,
                        input logic [24:0] f, input logic [6:0] op, input logic ordy,
                        output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_imm    = imm;
        in_type   = t;
        in_fields = f;
        in_opcode = op;
        out_ready = ordy;
        cnt_clr   = clr_req;
        #1;
        chk("err_count", 32'(err_count), 32'(cnt_model));
        if (stall_prev) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_instr", out_instr, prev_instr);
            chk("stall_err", 32'(out_err), 32'(prev_err));
        end
        if (ordy) chk("in_ready_open", 32'(in_ready), 32'd1);
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr", out_instr, e.instr);
                chk("sb_err", 32'(out_err), 32'(e.err));
`ifdef IMM_PACK_ERRCNT_EN
                if (e.err != 2'b00 && cnt_model < (1 << CW) - 1) cnt_model++;
`endif
            end
        end
`ifdef IMM_PACK_ERRCNT_EN
        if (clr_req) cnt_model = 0;
`endif
        stall_prev = out_valid && !ordy;
        prev_instr = out_instr;
        prev_err   = out_err;
        acc        = v && in_ready;
        if (acc) exp_q.push_back(model(imm, t, f, op));
    endtask

    task automatic idle(input logic ordy);
        logic a;
        step(1'b0, 32'h0, 3'd0, 25'h0, 7'h0, ordy, a);
    endtask

    initial begin
        logic        acc;
        int          idx;
        logic [31:0] bp_imm [4];
        logic [31:0] edge_imm [12];
        logic [31:0] imm;
        logic [2:0]  t;
        int          sel;

        checks     = 0;
        failures   = 0;
        cnt_model  = 0;
        stall_prev = 1'b0;
        prev_instr = '0;
        prev_err   = '0;
        clr_req    = 1'b0;
        in_valid   = 1'b0;
        in_imm     = '0;
        in_type    = '0;
        in_fields  = '0;
        in_opcode  = '0;
        out_ready  = 1'b0;
        cnt_clr    = 1'b0;
        rst_n      = 1'b1;
        #2 rst_n   = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // I-format with latency check
        step(1'b1, 32'hFFFFF800, 3'd0, 25'h000201, 7'h13, 1'b1, acc);
        chk("i_accept", 32'(acc), 32'd1);
        idle(1'b1);
        chk("i_not_early", 32'(out_valid), 32'd0);
        idle(1'b1);
        chk("i_valid", 32'(out_valid), 32'd1);
        chk("i_instr", out_instr, 32'h80010093);
        chk("i_err", 32'(out_err), 32'd0);

        // B-format: in range, then one past the range
        step(1'b1, 32'h00000FFE, 3'd1, 25'h0, 7'h63, 1'b1, acc);
        step(1'b1, 32'h00001000, 3'd1, 25'h0, 7'h63, 1'b1, acc);
        idle(1'b1);
        chk("b_instr", out_instr, 32'h7E000FE3);
        chk("b_err", 32'(out_err), 32'd0);
        idle(1'b1);
        chk("b_range_err", 32'(out_err), 32'd1);
        chk("b_range_instr", out_instr, 32'h80000063);

        // J misaligned, then bad type with odd immediate
        step(1'b1, 32'h00000003, 3'd4, 25'h0, 7'h6F, 1'b1, acc);
        step(1'b1, 32'h00000003, 3'd5, 25'h0, 7'h6F, 1'b1, acc);
        idle(1'b1);
        chk("j_align_err", 32'(out_err), 32'd2);
        idle(1'b1);
        chk("type_instr", out_instr, 32'hFFFFFFEF);
        chk("type_err", 32'(out_err), 32'd3);
        idle(1'b1);

        // Backpressure: 3 stalled cycles then release, 4 words in order with no gaps
        bp_imm[0] = 32'd11; bp_imm[1] = 32'd22; bp_imm[2] = 32'd33; bp_imm[3] = 32'd44;
        idx = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (idx < 4) step(1'b1, bp_imm[idx], 3'd0, 25'h00081, 7'h13, cyc >= 3, acc);
            else         step(1'b0, 32'h0, 3'd0, 25'h0, 7'h0, 1'b1, acc);
            if (acc) idx++;
            if (cyc == 2) begin
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                chk("bp_accepted", 32'(idx), 32'd2);
            end
            if (cyc >= 3 && cyc <= 6) chk("bp_no_gap", 32'(out_valid), 32'd1);
        end
        chk("bp_all_accepted", 32'(idx), 32'd4);

        // Reset with both stages full
        step(1'b1, 32'd7, 3'd0, 25'h0, 7'h13, 1'b0, acc);
        step(1'b1, 32'd8, 3'd0, 25'h0, 7'h13, 1'b0, acc);
        idle(1'b0);
        chk("full_before_rst", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_instr", out_instr, 32'd0);
        chk("midrst_err", 32'(out_err), 32'd0);
        exp_q.delete();
        stall_prev = 1'b0;
        cnt_model  = 0;
        in_valid   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'd5, 3'd0, 25'h0, 7'h13, 1'b1, acc);
        chk("post_rst_accept", 32'(acc), 32'd1);
        idle(1'b1);
        chk("post_rst_not_early", 32'(out_valid), 32'd0);
        idle(1'b1);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_instr", out_instr, 32'h00500013);
        idle(1'b1);

        // Error counter: saturation, then clear coincident with an error transfer
        for (int k = 0; k < 5; k++) step(1'b1, 32'h1, 3'd6, 25'h0, 7'h33, 1'b1, acc);
        repeat (3) idle(1'b1);
`ifdef IMM_PACK_ERRCNT_EN
        chk("cnt_saturated", 32'(err_count), 32'd3);
`else
        chk("cnt_disabled", 32'(err_count), 32'd0);
`endif
        step(1'b1, 32'h1, 3'd7, 25'h0, 7'h33, 1'b1, acc);
        idle(1'b1);
        clr_req = 1'b1;
        idle(1'b1);
        clr_req = 1'b0;
        chk("clr_coincident_xfer", 32'(out_valid), 32'd1);
        idle(1'b1);
        chk("cnt_cleared", 32'(err_count), 32'd0);

        // Randomized traffic against the reference model
        edge_imm[0]  = 32'd2047;      edge_imm[1]  = 32'hFFFFF800;
        edge_imm[2]  = 32'd2048;      edge_imm[3]  = 32'hFFFFF7FF;
        edge_imm[4]  = 32'd4094;      edge_imm[5]  = 32'd4096;
        edge_imm[6]  = 32'hFFFFF000;  edge_imm[7]  = 32'hFFFFEFFE;
        edge_imm[8]  = 32'h000FFFFE;  edge_imm[9]  = 32'h00100000;
        edge_imm[10] = 32'hFFF00000;  edge_imm[11] = 32'hFFEFFFFE;
        for (int n = 0; n < 600; n++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       imm = $urandom;
                1:       imm = 32'($signed($urandom_range(0, 8191)) - 4096);
                2:       imm = $urandom & 32'hFFFFF000;
                default: imm = edge_imm[$urandom_range(0, 11)];
            endcase
            t = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            clr_req = ($urandom_range(0, 31) == 0);
            step($urandom_range(0, 3) != 0, imm, t, 25'($urandom), 7'($urandom),
                 $urandom_range(0, 2) != 0, acc);
        end
        clr_req = 1'b0;
        for (int n = 0; n < 6; n++) idle(1'b1);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
